spi_accel_responder: RTL and testbench
======================================

Name: spi_accel_responder

Overview:
- SPI responder (peripheral side) for the accelerometer register protocol driven by the team's SPI master and serdes.
- Emulates an ADXL345-style register map: 16-bit frames, R/W bit, 6-bit address, 8-bit data.
- Host logic supplies X/Y/Z samples; the block exposes configuration written by the master.
- Uses: closed-loop simulation of the master, and FPGA-to-FPGA links where this board plays sensor.

Parameters:
- SYNC_STAGES, 2, synchronizer depth on SPI_CLK/SPI_CSN/SPI_SDI (min 2).
- DEVID_VALUE, 8'hE5, value returned at address 0x00.
- BW_RATE_RESET, 8'h0A, reset value of register 0x2C.

Ports:
- clk  in  1  system clock; must be >= 8x SPI_CLK frequency.
- reset_n  in  1  asynchronous active-low reset.
- sample_valid  in  1  one-cycle strobe; data_x/y/z valid.
- data_x  in  16  X sample, {HB,LB}.
- data_y  in  16  Y sample.
- data_z  in  16  Z sample.
- cfg_bw_rate  out  8  register 0x2C.
- cfg_power_ctl  out  8  register 0x2D.
- cfg_data_format  out  8  register 0x31.
- wr_strobe  out  1  one-cycle pulse on each committed write.
- wr_addr  out  6  address of the committed write.
- wr_data  out  8  data of the committed write.
- SPI_CLK  in  1  SPI clock from master; CPOL=1, CPHA=1.
- SPI_CSN  in  1  chip select, active low.
- SPI_SDI  in  1  master-to-responder data.
- SPI_SDO  out  1  responder-to-master data.
- SPI_SDO_OE  out  1  SDO drive enable; high only while SPI_CSN is low.

Behaviour:
- Clock and reset: one clock domain (clk), async active-low reset_n.
- Input synchronization:
  - SPI inputs pass through SYNC_STAGES flops.
  - rise/fall of SPI_CLK and fall/rise of SPI_CSN are edge-detected on synced values.
- Reset values:
  - SPI_SDO=0, SPI_SDO_OE=0, wr_strobe=0, wr_addr=0, wr_data=0.
  - cfg_bw_rate=BW_RATE_RESET; all other registers 0x00; state IDLE.
- Frame format, MSB first, sampled on SPI_CLK rising edge:
  - bit15 R/W (1=read).
  - bit14 MB (multi-byte).
  - bits13:8 address.
  - bits7:0 data.
- State machine:
  - IDLE: wait for CSN fall; snapshot shadow sample registers into read registers 0x32-0x37; bit counter=0 -> CMD.
  - CMD: shift 8 SDI bits; on the 8th rise, latch R/W, MB, addr.
    - Read: load read byte into the TX shift register -> DATA.
    - Write: -> DATA.
  - DATA, read: MSB driven on the first SCLK fall after CMD; next bit on each subsequent fall. After the 8th data rise -> DONE (or next byte, see Optional Feature).
  - DATA, write: shift 8 SDI bits. On the 8th rise, commit if the address is writable; wr_strobe pulses 1 cycle with wr_addr/wr_data -> DONE.
  - DONE: ignore further SCLK edges; SDO held at 0; wait for CSN rise -> IDLE.
- CSN rise in any state: return to IDLE within SYNC_STAGES+1 cycles; a partial write is discarded with no strobe.
- SDO timing: SDO updates within SYNC_STAGES+2 clk of the SCLK fall.
- Register map:
  - Writable: 0x24-0x2F and 0x31; writes elsewhere are ignored (no strobe).
  - Fixed and unused: 0x00 returns DEVID_VALUE; unimplemented addresses read 0x00.
  - Sample shadows: sample_valid loads them at any time. If it coincides with the CSN-fall snapshot cycle, the new sample is snapshotted.
  - 0x30 INT_SOURCE: bit7 DATA_READY, set by sample_valid, cleared when the 0x30 read byte is loaded; set wins if simultaneous. Other bits 0.
- SCLK edge while CSN is high: ignored.

Optional Feature:
- Macro: SPI_RESP_MULTIBYTE_EN.
- Defined:
  - With MB=1, after each data byte the address increments, wrapping 0x3F->0x00.
  - Reads: next byte loaded; continues until CSN rise.
  - Writes: each completed byte commits and pulses wr_strobe.
- Undefined: MB bit ignored; single byte per frame, then DONE.

Decomposition:
- Package spi_accel_pkg:
  - register address localparams (shared with the master's table);
  - READ_MODE/WRITE_MODE;
  - responder state enum {IDLE, CMD, DATA, DONE};
  - reset-value constants.
- Sub-module spi_resp_sync: synchronizer chain plus edge detect for SCLK/CSN; SDI synced only.

Test Plan:
- Reset, no SPI activity -> cfg_bw_rate=0x0A, cfg_power_ctl=0x00, SDO_OE=0, wr_strobe never asserts.
- Write frame 0x2D08 -> cfg_power_ctl=0x08 one cycle after the 16th rise; exactly one wr_strobe with wr_addr=0x2D, wr_data=0x08.
- Read frame 0x80xx -> master captures 0xE5 on SDO bits 7:0.
- data_x=0x1234 with sample_valid, then read 0xB2 and 0xB3 -> 0x34 then 0x12; INT_SOURCE read returns 0x80, second read 0x00.
- CSN raised after 12 bits of write 0x2C0F -> cfg_bw_rate stays 0x0A, no strobe; next full frame is decoded correctly.
- With SPI_RESP_MULTIBYTE_EN: read 0xF2 + 48 SCLKs, data_x/y/z=0x1122/0x3344/0x5566 -> bytes 22,11,44,33,66,55; sample_valid mid-frame does not alter the sequence.

Source files
------------

// File: rtl/spi_accel_pkg.sv
// Shared definitions for the accelerometer SPI responder: register map
// addresses, frame direction codes, responder states, reset constants and
// small address helpers.
package spi_accel_pkg;

  // Register addresses, shared with the master's register table
  localparam logic [5:0] ADDR_DEVID       = 6'h00;
  localparam logic [5:0] ADDR_FIRST_CTRL  = 6'h24;
  localparam logic [5:0] ADDR_BW_RATE     = 6'h2C;
  localparam logic [5:0] ADDR_POWER_CTL   = 6'h2D;
  localparam logic [5:0] ADDR_LAST_CTRL   = 6'h2F;
  localparam logic [5:0] ADDR_INT_SOURCE  = 6'h30;
  localparam logic [5:0] ADDR_DATA_FORMAT = 6'h31;
  localparam logic [5:0] ADDR_DATAX0      = 6'h32;
  localparam logic [5:0] ADDR_DATAZ1      = 6'h37;

  // R/W bit of the command byte
  localparam logic READ_MODE  = 1'b1;
  localparam logic WRITE_MODE = 1'b0;

  // Reset-value constants
  localparam logic [7:0] DEVID_DEFAULT   = 8'hE5;
  localparam logic [7:0] BW_RATE_DEFAULT = 8'h0A;
  localparam logic [7:0] REG_RESET       = 8'h00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } resp_state_t;

  // Registers the master may write: 0x24..0x2F and 0x31
  function automatic logic is_writable(input logic [5:0] a);
    return ((a >= ADDR_FIRST_CTRL) && (a <= ADDR_LAST_CTRL)) || (a == ADDR_DATA_FORMAT);
  endfunction

  // Index into the 12-entry control block for addresses 0x24..0x2F
  function automatic logic [3:0] ctrl_idx(input logic [5:0] a);
    return a[3:0] - 4'd4;
  endfunction

  // Index into the 6-entry sample snapshot for addresses 0x32..0x37
  function automatic logic [2:0] snap_idx(input logic [5:0] a);
    return a[2:0] - 3'd2;
  endfunction

endpackage

// File: rtl/spi_resp_sync.sv
// Synchronizer chains for the SPI inputs into the clk domain, with edge
// detection on SCLK and a falling-edge detect on CSN. SDI is only synced.
module spi_resp_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic spi_clk,
  input  logic spi_csn,
  input  logic spi_sdi,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic csn_fall,
  output logic csn_high,
  output logic sdi
);

  logic [SYNC_STAGES-1:0] sclk_chain;
  logic [SYNC_STAGES-1:0] csn_chain;
  logic [SYNC_STAGES-1:0] sdi_chain;
  logic                   sclk_prev;
  logic                   csn_prev;

  // Shift raw pins through the chains; SCLK and CSN idle high (CPOL=1, deselected)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_chain <= '1;
      csn_chain  <= '1;
      sdi_chain  <= '0;
      sclk_prev  <= 1'b1;
      csn_prev   <= 1'b1;
    end else begin
      sclk_chain <= {sclk_chain[SYNC_STAGES-2:0], spi_clk};
      csn_chain  <= {csn_chain[SYNC_STAGES-2:0], spi_csn};
      sdi_chain  <= {sdi_chain[SYNC_STAGES-2:0], spi_sdi};
      sclk_prev  <= sclk_chain[SYNC_STAGES-1];
      csn_prev   <= csn_chain[SYNC_STAGES-1];
    end
  end

  assign sclk_rise = sclk_chain[SYNC_STAGES-1] & ~sclk_prev;
  assign sclk_fall = ~sclk_chain[SYNC_STAGES-1] & sclk_prev;
  assign csn_fall  = ~csn_chain[SYNC_STAGES-1] & csn_prev;
  assign csn_high  = csn_chain[SYNC_STAGES-1];
  assign sdi       = sdi_chain[SYNC_STAGES-1];

endmodule

// File: rtl/spi_accel_responder.sv
// ADXL345-style SPI responder (CPOL=1, CPHA=1, 16-bit frames, MSB first).
// Optional feature macro: SPI_RESP_MULTIBYTE_EN -- when defined, MB=1 frames
// auto-increment the address after each data byte; otherwise one byte per frame.
module spi_accel_responder
  import spi_accel_pkg::*;
#(
  parameter int         SYNC_STAGES   = 2,
  parameter logic [7:0] DEVID_VALUE   = DEVID_DEFAULT,
  parameter logic [7:0] BW_RATE_RESET = BW_RATE_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        sample_valid,
  input  logic [15:0] data_x,
  input  logic [15:0] data_y,
  input  logic [15:0] data_z,
  output logic [7:0]  cfg_bw_rate,
  output logic [7:0]  cfg_power_ctl,
  output logic [7:0]  cfg_data_format,
  output logic        wr_strobe,
  output logic [5:0]  wr_addr,
  output logic [7:0]  wr_data,
  input  logic        SPI_CLK,
  input  logic        SPI_CSN,
  input  logic        SPI_SDI,
  output logic        SPI_SDO,
  output logic        SPI_SDO_OE
);

`ifdef SPI_RESP_MULTIBYTE_EN
  localparam logic MB_EN = 1'b1;
`else
  localparam logic MB_EN = 1'b0;
`endif

  logic        sclk_rise, sclk_fall, csn_fall, csn_high, sdi;

  resp_state_t state;
  logic [2:0]  bit_cnt;
  logic [6:0]  rx_shift;
  logic [7:0]  tx_shift;
  logic        rw, mb;
  logic [5:0]  addr;
  logic        sdo, oe;

  logic [7:0]  ctrl_regs [0:11];
  logic [7:0]  data_format;
  logic [7:0]  shadow [0:5];
  logic [7:0]  snap [0:5];
  logic [7:0]  sample_bytes [0:5];
  logic        data_ready;

  logic        byte_done, load_rd, commit, next_mb;
  logic [7:0]  rx_byte, rd_byte;
  logic [5:0]  load_addr;

  spi_resp_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .reset_n   (reset_n),
    .spi_clk   (SPI_CLK),
    .spi_csn   (SPI_CSN),
    .spi_sdi   (SPI_SDI),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .csn_fall  (csn_fall),
    .csn_high  (csn_high),
    .sdi       (sdi)
  );

  assign sample_bytes[0] = data_x[7:0];
  assign sample_bytes[1] = data_x[15:8];
  assign sample_bytes[2] = data_y[7:0];
  assign sample_bytes[3] = data_y[15:8];
  assign sample_bytes[4] = data_z[7:0];
  assign sample_bytes[5] = data_z[15:8];

  assign rx_byte   = {rx_shift, sdi};
  assign byte_done = sclk_rise && (bit_cnt == 3'd7);
  assign next_mb   = mb && MB_EN;
  // The command byte supplies the first address; later bytes use the next address
  assign load_addr = (state == CMD) ? {rx_shift[4:0], sdi} : addr + 6'd1;
  assign load_rd   = !csn_high && byte_done &&
                     (((state == CMD) && (rx_shift[6] == READ_MODE)) ||
                      ((state == DATA) && (rw == READ_MODE) && next_mb));
  assign commit    = !csn_high && byte_done && (state == DATA) &&
                     (rw == WRITE_MODE) && is_writable(addr);

  // Read-data multiplexer for the byte about to enter the TX shift register
  always_comb begin
    rd_byte = REG_RESET;
    if (load_addr == ADDR_DEVID)
      rd_byte = DEVID_VALUE;
    else if ((load_addr >= ADDR_FIRST_CTRL) && (load_addr <= ADDR_LAST_CTRL))
      rd_byte = ctrl_regs[ctrl_idx(load_addr)];
    else if (load_addr == ADDR_INT_SOURCE)
      rd_byte = {data_ready, 7'd0};
    else if (load_addr == ADDR_DATA_FORMAT)
      rd_byte = data_format;
    else if ((load_addr >= ADDR_DATAX0) && (load_addr <= ADDR_DATAZ1))
      rd_byte = snap[snap_idx(load_addr)];
  end

  // Frame sequencer: command byte, data byte(s), then hold until deselect
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      bit_cnt  <= 3'd0;
      rx_shift <= 7'd0;
      tx_shift <= 8'd0;
      rw       <= 1'b0;
      mb       <= 1'b0;
      addr     <= 6'd0;
      sdo      <= 1'b0;
      oe       <= 1'b0;
    end else if (csn_high) begin
      state   <= IDLE;
      bit_cnt <= 3'd0;
      sdo     <= 1'b0;
      oe      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (csn_fall) begin
            state   <= CMD;
            bit_cnt <= 3'd0;
            sdo     <= 1'b0;
            oe      <= 1'b1;
          end
        end
        CMD: begin
          if (sclk_rise) begin
            rx_shift <= rx_byte[6:0];
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              rw    <= rx_shift[6];
              mb    <= rx_shift[5];
              addr  <= load_addr;
              state <= DATA;
              if (rx_shift[6] == READ_MODE)
                tx_shift <= rd_byte;
            end
          end
        end
        DATA: begin
          if ((rw == READ_MODE) && sclk_fall) begin
            sdo      <= tx_shift[7];
            tx_shift <= {tx_shift[6:0], 1'b0};
          end
          if (sclk_rise) begin
            rx_shift <= rx_byte[6:0];
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (next_mb) begin
                addr <= addr + 6'd1;
                if (rw == READ_MODE)
                  tx_shift <= rd_byte;
              end else begin
                state <= DONE;
                sdo   <= 1'b0;
              end
            end
          end
        end
        default: sdo <= 1'b0;
      endcase
    end
  end

  // Writable register file: control block 0x24..0x2F plus DATA_FORMAT
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 12; i++)
        ctrl_regs[i] <= (i == int'(ctrl_idx(ADDR_BW_RATE))) ? BW_RATE_RESET : REG_RESET;
      data_format <= REG_RESET;
    end else if (commit) begin
      if (addr == ADDR_DATA_FORMAT)
        data_format <= rx_byte;
      else
        ctrl_regs[ctrl_idx(addr)] <= rx_byte;
    end
  end

  // Committed-write notification
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_strobe <= 1'b0;
      wr_addr   <= 6'd0;
      wr_data   <= 8'd0;
    end else begin
      wr_strobe <= commit;
      if (commit) begin
        wr_addr <= addr;
        wr_data <= rx_byte;
      end
    end
  end

  // Sample shadows track the host; snapshot at frame start so a frame reads one coherent sample
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 6; i++) begin
        shadow[i] <= REG_RESET;
        snap[i]   <= REG_RESET;
      end
    end else begin
      for (int i = 0; i < 6; i++) begin
        if (sample_valid)
          shadow[i] <= sample_bytes[i];
        if ((state == IDLE) && csn_fall && !csn_high)
          snap[i] <= sample_valid ? sample_bytes[i] : shadow[i];
      end
    end
  end

  // DATA_READY: new sample sets it, loading INT_SOURCE for readout clears it; set wins
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      data_ready <= 1'b0;
    else if (sample_valid)
      data_ready <= 1'b1;
    else if (load_rd && (load_addr == ADDR_INT_SOURCE))
      data_ready <= 1'b0;
  end

  assign cfg_bw_rate     = ctrl_regs[ctrl_idx(ADDR_BW_RATE)];
  assign cfg_power_ctl   = ctrl_regs[ctrl_idx(ADDR_POWER_CTL)];
  assign cfg_data_format = data_format;
  assign SPI_SDO         = sdo;
  // Gate with the raw pin so the driver is released as soon as the master deselects
  assign SPI_SDO_OE      = oe & ~SPI_CSN;

endmodule

// File: tb/tb_spi_accel_responder.sv
// Directed bench for spi_accel_responder: SPI master task, transaction-level
// register model, per-cycle compare of configuration outputs and write strobes.
module tb_spi_accel_responder;

`ifdef SPI_RESP_MULTIBYTE_EN
  localparam bit MB_TB = 1'b1;
`else
  localparam bit MB_TB = 1'b0;
`endif
  localparam int HALF = 80;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        sample_valid = 1'b0;
  logic [15:0] data_x = 16'd0, data_y = 16'd0, data_z = 16'd0;
  logic [7:0]  cfg_bw_rate, cfg_power_ctl, cfg_data_format;
  logic        wr_strobe;
  logic [5:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        SPI_CLK = 1'b1, SPI_CSN = 1'b1, SPI_SDI = 1'b0;
  logic        SPI_SDO, SPI_SDO_OE;

  spi_accel_responder dut (
    .clk(clk), .reset_n(reset_n), .sample_valid(sample_valid),
    .data_x(data_x), .data_y(data_y), .data_z(data_z),
    .cfg_bw_rate(cfg_bw_rate), .cfg_power_ctl(cfg_power_ctl),
    .cfg_data_format(cfg_data_format), .wr_strobe(wr_strobe),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .SPI_CLK(SPI_CLK), .SPI_CSN(SPI_CSN), .SPI_SDI(SPI_SDI),
    .SPI_SDO(SPI_SDO), .SPI_SDO_OE(SPI_SDO_OE)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;
  int n_strobes = 0;
  bit chk_en = 1'b0;
  bit prev_strobe = 1'b0;

  typedef struct packed { logic [5:0] a; logic [7:0] d; } wr_t;
  wr_t exp_wr[$];

  // Register model
  logic [7:0]  mreg [64];
  logic [15:0] mx = 16'd0, my = 16'd0, mz = 16'd0;
  logic        mdr = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic bit model_writable(input logic [5:0] a);
    return (a >= 6'h24 && a <= 6'h2F) || a == 6'h31;
  endfunction

  function automatic logic [7:0] model_read(input logic [5:0] a);
    if (a == 6'h00) return 8'hE5;
    if (model_writable(a)) return mreg[a];
    case (a)
      6'h30: return {mdr, 7'd0};
      6'h32: return mx[7:0];
      6'h33: return mx[15:8];
      6'h34: return my[7:0];
      6'h35: return my[15:8];
      6'h36: return mz[7:0];
      6'h37: return mz[15:8];
      default: return 8'h00;
    endcase
  endfunction

  // Expected SDO stream and writes for a frame of nbits, applied to the model
  task automatic model_frame(input logic [63:0] tx, input int nbits, output logic [63:0] exp_rx);
    logic [63:0] t;
    logic [7:0]  cmd, b;
    logic [5:0]  a;
    logic        rd, multi;
    int          nbytes, sh;
    wr_t         w;
    t = tx >> (nbits - 8);
    cmd = t[7:0];
    rd = cmd[7];
    multi = cmd[6] & MB_TB;
    a = cmd[5:0];
    nbytes = (nbits - 8) / 8;
    exp_rx = 64'd0;
    for (int k = 0; k < nbytes; k++) begin
      if (k > 0 && !multi) break;
      sh = nbits - 16 - 8 * k;
      if (rd) begin
        b = model_read(a);
        if (a == 6'h30) mdr = 1'b0;
        exp_rx = exp_rx | ({56'd0, b} << sh);
      end else begin
        t = tx >> sh;
        b = t[7:0];
        if (model_writable(a)) begin
          mreg[a] = b;
          w.a = a;
          w.d = b;
          exp_wr.push_back(w);
        end
      end
      a = a + 6'd1;
    end
  endtask

  // SPI master, mode 3: drive on falling edge, sample on rising edge
  task automatic spi_xfer(input logic [63:0] tx, input int nbits, output logic [63:0] rx);
    rx = 64'd0;
    SPI_CSN = 1'b0;
    #(HALF);
    for (int i = nbits - 1; i >= 0; i--) begin
      SPI_CLK = 1'b0;
      SPI_SDI = tx[i];
      #(HALF);
      SPI_CLK = 1'b1;
      rx[i] = SPI_SDO;
      if (i == 0) check("sdo_oe_active", SPI_SDO_OE, 1);
      #(HALF);
    end
    SPI_CSN = 1'b1;
    #(2 * HALF);
  endtask

  task automatic finish_frame(input string name, input logic [63:0] rx, input logic [63:0] exp_rx);
    check({name, "_sdo"}, rx, exp_rx);
    check({name, "_wr_drain"}, exp_wr.size(), 0);
    chk_en = 1'b1;
  endtask

  task automatic frame(input string name, input logic [63:0] tx, input int nbits, output logic [63:0] rx);
    logic [63:0] exp_rx;
    chk_en = 1'b0;
    model_frame(tx, nbits, exp_rx);
    spi_xfer(tx, nbits, rx);
    finish_frame(name, rx, exp_rx);
  endtask

  task automatic pulse_sample(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    @(negedge clk);
    data_x = x; data_y = y; data_z = z;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  // Per-cycle compare of configuration outputs and committed writes
  always @(negedge clk) begin : compare
    wr_t w;
    if (chk_en) begin
      check("cfg_bw_rate", cfg_bw_rate, mreg[6'h2C]);
      check("cfg_power_ctl", cfg_power_ctl, mreg[6'h2D]);
      check("cfg_data_format", cfg_data_format, mreg[6'h31]);
      check("sdo_oe_idle", SPI_SDO_OE, 0);
    end
    if (reset_n && wr_strobe) begin
      n_strobes++;
      check("wr_strobe_width", prev_strobe, 0);
      check("wr_strobe_expected", exp_wr.size() > 0, 1);
      if (exp_wr.size() > 0) begin
        w = exp_wr.pop_front();
        check("wr_addr", wr_addr, w.a);
        check("wr_data", wr_data, w.d);
      end
    end
    prev_strobe = wr_strobe;
  end

  initial begin : watchdog
    #(3ms);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [63:0] rx, exp_rx;
    for (int i = 0; i < 64; i++) mreg[i] = 8'h00;
    mreg[6'h2C] = 8'h0A;

    #20;
    check("rst_wr_strobe", wr_strobe, 0);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_bw_rate", cfg_bw_rate, 8'h0A);
    check("rst_power_ctl", cfg_power_ctl, 8'h00);
    check("rst_data_format", cfg_data_format, 8'h00);
    check("rst_sdo_oe", SPI_SDO_OE, 0);
    check("rst_sdo", SPI_SDO, 0);
    check("rst_wr_addr", wr_addr, 6'h00);
    check("rst_wr_data", wr_data, 8'h00);
    chk_en = 1'b1;
    repeat (20) @(negedge clk);

    // Single-byte write to POWER_CTL
    frame("wr_2d", 64'h2D08, 16, rx);
    check("power_ctl_lit", cfg_power_ctl, 8'h08);
    check("strobe_count_lit", n_strobes, 1);
    check("wr_addr_lit", wr_addr, 6'h2D);
    check("wr_data_lit", wr_data, 8'h08);

    // DEVID read
    frame("rd_devid", 64'h8000, 16, rx);
    check("devid_lit", rx[7:0], 8'hE5);

    // Sample readback and DATA_READY clear-on-read
    pulse_sample(16'h1234, 16'h0000, 16'h0000);
    mx = 16'h1234; my = 16'h0000; mz = 16'h0000; mdr = 1'b1;
    frame("rd_x0", 64'hB200, 16, rx);
    check("datax0_lit", rx[7:0], 8'h34);
    frame("rd_x1", 64'hB300, 16, rx);
    check("datax1_lit", rx[7:0], 8'h12);
    frame("rd_int1", 64'hB000, 16, rx);
    check("int_src1_lit", rx[7:0], 8'h80);
    frame("rd_int2", 64'hB000, 16, rx);
    check("int_src2_lit", rx[7:0], 8'h00);

    // Aborted write after 12 bits, then the full frame
    frame("wr_partial", 64'h2C0, 12, rx);
    check("bw_after_partial_lit", cfg_bw_rate, 8'h0A);
    frame("wr_2c", 64'h2C0F, 16, rx);
    check("bw_full_lit", cfg_bw_rate, 8'h0F);

    // Write to a read-only address, then DATA_FORMAT write and readback
    frame("wr_ro", 64'h0055, 16, rx);
    frame("wr_31", 64'h310B, 16, rx);
    frame("rd_31", 64'hB100, 16, rx);
    check("data_format_lit", rx[7:0], 8'h0B);

    // Multi-byte sample read with a new sample arriving mid-frame
    pulse_sample(16'h1122, 16'h3344, 16'h5566);
    mx = 16'h1122; my = 16'h3344; mz = 16'h5566; mdr = 1'b1;
    chk_en = 1'b0;
    model_frame(64'hF2 << 48, 56, exp_rx);
    fork
      spi_xfer(64'hF2 << 48, 56, rx);
      begin
        #(HALF * 40);
        pulse_sample(16'hAAAA, 16'hBBBB, 16'hCCCC);
      end
    join
    mx = 16'hAAAA; my = 16'hBBBB; mz = 16'hCCCC; mdr = 1'b1;
    finish_frame("rd_mb", rx, exp_rx);
    if (MB_TB) check("mb_read_lit", rx[47:0], 48'h221144336655);
    else       check("mb_read_lit", rx[47:0], 48'h220000000000);

    // Multi-byte write starting at BW_RATE
    frame("wr_mb", 64'h6C0C09, 24, rx);
    check("mb_bw_lit", cfg_bw_rate, 8'h0C);
    if (MB_TB) check("mb_pwr_lit", cfg_power_ctl, 8'h09);
    else       check("mb_pwr_lit", cfg_power_ctl, 8'h08);

    // SCLK activity with CSN high must be ignored
    for (int i = 0; i < 16; i++) begin
      SPI_CLK = 1'b0;
      SPI_SDI = i[0];
      #(HALF);
      SPI_CLK = 1'b1;
      #(HALF);
    end
    frame("rd_devid2", 64'h8000, 16, rx);
    check("devid2_lit", rx[7:0], 8'hE5);

    repeat (10) @(negedge clk);
    check("final_wr_queue", exp_wr.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
